apb_uart_arbiter: RTL and testbench

APB_UART_ARBITER -- requirements
Module: apb_uart_arbiter

---
 rtl/apb_uart_pkg.sv | 18 +
 rtl/apb_rr_arbiter.sv | 34 +++
 rtl/apb_uart_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_apb_uart_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_uart_pkg.sv
// Shared types and constants for the APB UART arbiter: FSM states, UART register map, default timeout.
package apb_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } apb_state_t;

  localparam logic [31:0] REG_CTRL  = 32'h0000_0000;
  localparam logic [31:0] REG_STATS = 32'h0000_0001;
  localparam logic [31:0] REG_TX    = 32'h0000_0002;
  localparam logic [31:0] REG_RX    = 32'h0000_0003;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping, as a one-hot grant.
module apb_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant_c
);

  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  always_comb begin : p_pick
    o_grant_c = '0;
    w_found   = 1'b0;
    w_sum     = '0;
    w_idx     = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      // Extra sum bit keeps the wrap correct for non-power-of-two NUM_REQ
      w_sum = {1'b0, i_ptr} + (PTR_W+1)'(off);
      if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
      end
      w_idx = w_sum[PTR_W-1:0];
      if (!w_found && i_req[w_idx]) begin
        o_grant_c[w_idx] = 1'b1;
        w_found          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_uart_arbiter.sv
// Round-robin arbiter that serialises several requesters onto one APB master port.
// Optional APB_TIMEOUT_EN adds an ACCESS-phase PREADY timeout reported on rsp_err.
module apb_uart_arbiter
  import apb_uart_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [32*NUM_REQ-1:0] req_addr,
  input  logic [32*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    ack,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [31:0]           PADDR,
  output logic [31:0]           PWDATA,
  input  logic [31:0]           PRDATA,
  input  logic                  PREADY
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("apb_uart_arbiter: NUM_REQ must be 2..4 and TIMEOUT_CYCLES >= 1");
  end

  apb_state_t         r_state, w_state_nxt;
  logic               r_psel, w_psel_nxt;
  logic               r_penable, w_penable_nxt;
  logic               r_pwrite, w_pwrite_nxt;
  logic [31:0]        r_paddr, w_paddr_nxt;
  logic [31:0]        r_pwdata, w_pwdata_nxt;
  logic [NUM_REQ-1:0] r_ack, w_ack_nxt;
  logic [31:0]        r_rdata, w_rdata_nxt;
  logic               r_busy, w_busy_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
  logic [NUM_REQ-1:0] w_arb_gnt;
  logic [PTR_W-1:0]   w_gnt_idx;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic             r_err, w_err_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
`endif

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .i_req     (req),
    .i_ptr     (r_ptr),
    .o_grant_c (w_arb_gnt)
  );

  // Index of the requester currently holding the bus, for the pointer update
  always_comb begin : p_gnt_idx
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_gnt[i]) w_gnt_idx = PTR_W'(i);
    end
  end

  always_comb begin : p_next
    w_state_nxt   = r_state;
    w_psel_nxt    = 1'b0;
    w_penable_nxt = 1'b0;
    w_pwrite_nxt  = r_pwrite;
    w_paddr_nxt   = r_paddr;
    w_pwdata_nxt  = r_pwdata;
    w_ack_nxt     = '0;
    w_rdata_nxt   = r_rdata;
    w_gnt_nxt     = r_gnt;
    w_ptr_nxt     = r_ptr;
`ifdef APB_TIMEOUT_EN
    w_err_nxt     = r_err;
    w_cnt_nxt     = r_cnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_state_nxt = ST_SETUP;
          w_psel_nxt  = 1'b1;
          w_gnt_nxt   = w_arb_gnt;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (w_arb_gnt[i]) begin
              w_pwrite_nxt = req_write[i];
              w_paddr_nxt  = req_addr[i*32 +: 32];
              w_pwdata_nxt = req_wdata[i*32 +: 32];
            end
          end
        end
      end
      ST_SETUP: begin
        w_state_nxt   = ST_ACCESS;
        w_psel_nxt    = 1'b1;
        w_penable_nxt = 1'b1;
`ifdef APB_TIMEOUT_EN
        w_cnt_nxt     = '0;
`endif
      end
      ST_ACCESS: begin
        w_psel_nxt    = 1'b1;
        w_penable_nxt = 1'b1;
        if (PREADY) begin
          w_state_nxt   = ST_DONE;
          w_psel_nxt    = 1'b0;
          w_penable_nxt = 1'b0;
          w_ack_nxt     = r_gnt;
          w_rdata_nxt   = r_pwrite ? 32'h0 : PRDATA;
`ifdef APB_TIMEOUT_EN
          w_err_nxt     = 1'b0;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt   = ST_DONE;
          w_psel_nxt    = 1'b0;
          w_penable_nxt = 1'b0;
          w_ack_nxt     = r_gnt;
          w_rdata_nxt   = 32'h0;
          w_err_nxt     = 1'b1;
        end else begin
          w_cnt_nxt     = r_cnt + CNT_W'(1);
`endif
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_ptr_nxt   = (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge PCLK) begin : p_regs
    if (!PRESETn) begin
      r_state   <= ST_IDLE;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_ack     <= '0;
      r_rdata   <= '0;
      r_busy    <= 1'b0;
      r_gnt     <= '0;
      r_ptr     <= '0;
`ifdef APB_TIMEOUT_EN
      r_err     <= 1'b0;
      r_cnt     <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_psel    <= w_psel_nxt;
      r_penable <= w_penable_nxt;
      r_pwrite  <= w_pwrite_nxt;
      r_paddr   <= w_paddr_nxt;
      r_pwdata  <= w_pwdata_nxt;
      r_ack     <= w_ack_nxt;
      r_rdata   <= w_rdata_nxt;
      r_busy    <= w_busy_nxt;
      r_gnt     <= w_gnt_nxt;
      r_ptr     <= w_ptr_nxt;
`ifdef APB_TIMEOUT_EN
      r_err     <= w_err_nxt;
      r_cnt     <= w_cnt_nxt;
`endif
    end
  end

  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign ack       = r_ack;
  assign rsp_rdata = r_rdata;
  assign busy      = r_busy;
`ifdef APB_TIMEOUT_EN
  assign rsp_err   = r_err;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_apb_uart_arbiter.sv
// Directed bench for apb_uart_arbiter (NUM_REQ=2): vector table plus hand-written corner sequences.
module tb_apb_uart_arbiter;
  import apb_uart_pkg::*;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [1:0]  req, req_write;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  ack;
  logic [31:0] rsp_rdata;
  logic        rsp_err, busy, PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        idx;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          wait_c;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[4];

  apb_uart_arbiter dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (ack),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY)
  );

  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input logic i, input logic wr, input logic [31:0] a, input logic [31:0] d);
    req_write[i] = wr;
    if (i) begin
      req_addr[63:32]  = a;
      req_wdata[63:32] = d;
    end else begin
      req_addr[31:0]  = a;
      req_wdata[31:0] = d;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ack"},     32'(ack), 32'h0);
    chk({tag, " rdata"},   rsp_rdata, 32'h0);
    chk({tag, " err"},     32'(rsp_err), 32'h0);
    chk({tag, " busy"},    32'(busy), 32'h0);
    chk({tag, " psel"},    32'(PSEL), 32'h0);
    chk({tag, " penable"}, 32'(PENABLE), 32'h0);
    chk({tag, " pwrite"},  32'(PWRITE), 32'h0);
    chk({tag, " paddr"},   PADDR, 32'h0);
    chk({tag, " pwdata"},  PWDATA, 32'h0);
  endtask

  task automatic do_reset();
    PRESETn = 1'b0;
    tick();
    PRESETn = 1'b1;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    logic [1:0] oh;
    string      t;
    t = $sformatf("vec%0d", n);
    oh = 2'b00;
    oh[v.idx] = 1'b1;
    set_req(v.idx, v.wr, v.addr, v.wdata);
    req[v.idx] = 1'b1;
    PREADY = 1'b0;
    tick();
    chk({t, " setup psel"},    32'(PSEL), 32'h1);
    chk({t, " setup penable"}, 32'(PENABLE), 32'h0);
    chk({t, " setup busy"},    32'(busy), 32'h1);
    chk({t, " paddr"},         PADDR, v.addr);
    chk({t, " pwrite"},        32'(PWRITE), 32'(v.wr));
    tick();
    chk({t, " access penable"}, 32'(PENABLE), 32'h1);
    chk({t, " pwdata"},         PWDATA, v.wdata);
    for (int w = 0; w < v.wait_c; w++) begin
      tick();
      chk({t, " wait ack"},   32'(ack), 32'h0);
      chk({t, " wait paddr"}, PADDR, v.addr);
    end
    PREADY = 1'b1;
    PRDATA = v.prdata;
    tick();
    chk({t, " ack"},       32'(ack), 32'(oh));
    chk({t, " rdata"},     rsp_rdata, v.exp_rdata);
    chk({t, " err"},       32'(rsp_err), 32'h0);
    chk({t, " done psel"}, 32'(PSEL), 32'h0);
    req[v.idx] = 1'b0;
    PREADY = 1'b0;
    PRDATA = 32'h0;
    tick();
    chk({t, " idle ack"},  32'(ack), 32'h0);
    chk({t, " idle busy"}, 32'(busy), 32'h0);
    chk({t, " idle psel"}, 32'(PSEL), 32'h0);
  endtask

  initial begin
    logic       e;
    logic [1:0] oh;
    PRESETn   = 1'b0;
    req       = 2'b00;
    req_write = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    PRDATA    = 32'h0;
    PREADY    = 1'b0;

    vecs[0] = '{1'b0, 1'b1, REG_TX,    32'h0000_0055, 32'h0000_0000, 1, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b0, REG_RX,    32'h0000_0000, 32'h0000_00A5, 0, 32'h0000_00A5};
    vecs[2] = '{1'b0, 1'b0, REG_CTRL,  32'h0000_0000, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 1'b1, REG_STATS, 32'h1234_5678, 32'hFFFF_FFFF, 0, 32'h0000_0000};

    tick();
    tick();
    chk_all_zero("reset");
    PRESETn = 1'b1;
    tick();

    for (int v = 0; v < 4; v++) run_vec(v, vecs[v]);

    // Contention: both requesting, PREADY always high; expect 0,1,0,1 with an IDLE gap
    do_reset();
    set_req(1'b0, 1'b0, REG_CTRL, 32'h0);
    set_req(1'b1, 1'b0, REG_STATS, 32'h0);
    PRDATA = 32'h0000_CAFE;
    PREADY = 1'b1;
    req    = 2'b11;
    for (int t = 0; t < 4; t++) begin
      e  = ((t % 2) == 1);
      oh = e ? 2'b10 : 2'b01;
      tick();
      chk("cont setup psel",    32'(PSEL), 32'h1);
      chk("cont setup penable", 32'(PENABLE), 32'h0);
      chk("cont paddr",         PADDR, e ? REG_STATS : REG_CTRL);
      tick();
      chk("cont access penable", 32'(PENABLE), 32'h1);
      tick();
      chk("cont ack",   32'(ack), 32'(oh));
      chk("cont rdata", rsp_rdata, 32'h0000_CAFE);
      tick();
      chk("cont gap psel", 32'(PSEL), 32'h0);
      chk("cont gap busy", 32'(busy), 32'h0);
      if (t == 3) req = 2'b00;
    end
    PREADY = 1'b0;
    tick();

    // Reset in ACCESS: complete one read on req0 so the pointer moves to 1, then abort req1
    do_reset();
    set_req(1'b0, 1'b0, REG_RX, 32'h0);
    set_req(1'b1, 1'b1, REG_TX, 32'h0000_0077);
    req    = 2'b01;
    PRDATA = 32'h0000_5A5A;
    PREADY = 1'b1;
    tick();
    tick();
    tick();
    chk("rst pre ack",   32'(ack), 32'h1);
    chk("rst pre rdata", rsp_rdata, 32'h0000_5A5A);
    req    = 2'b00;
    PREADY = 1'b0;
    tick();
    req = 2'b10;
    tick();
    tick();
    chk("rst access penable", 32'(PENABLE), 32'h1);
    chk("rst access pwrite",  32'(PWRITE), 32'h1);
    PRESETn = 1'b0;
    req     = 2'b00;
    tick();
    chk_all_zero("rst mid");
    PRESETn = 1'b1;
    PREADY  = 1'b1;
    tick();
    chk("rst after ack0", 32'(ack), 32'h0);
    tick();
    chk("rst after ack1", 32'(ack), 32'h0);
    chk("rst after psel", 32'(PSEL), 32'h0);
    req = 2'b11;
    tick();
    chk("rst ptr paddr", PADDR, REG_RX);
    tick();
    tick();
    chk("rst ptr ack", 32'(ack), 32'h1);
    req    = 2'b00;
    PREADY = 1'b0;
    tick();

    // Dropped request in SETUP; non-granted requester changes during ACCESS
    set_req(1'b0, 1'b1, REG_CTRL, 32'h0000_00C3);
    set_req(1'b1, 1'b0, REG_STATS, 32'h0);
    req = 2'b01;
    tick();
    chk("drop setup psel", 32'(PSEL), 32'h1);
    req = 2'b00;
    tick();
    chk("drop access penable", 32'(PENABLE), 32'h1);
    set_req(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    req = 2'b10;
    tick();
    chk("other paddr",  PADDR, REG_CTRL);
    chk("other pwdata", PWDATA, 32'h0000_00C3);
    chk("other pwrite", 32'(PWRITE), 32'h1);
    PREADY = 1'b1;
    tick();
    chk("drop ack",  32'(ack), 32'h1);
    chk("drop err",  32'(rsp_err), 32'h0);
    req    = 2'b00;
    PREADY = 1'b0;
    tick();
    chk("drop idle ack",  32'(ack), 32'h0);
    chk("drop idle busy", 32'(busy), 32'h0);

`ifdef APB_TIMEOUT_EN
    // PREADY never arrives: ack lands after 16 ACCESS cycles with rsp_err set
    set_req(1'b0, 1'b0, REG_RX, 32'h0);
    PRDATA = 32'h1111_2222;
    req    = 2'b01;
    tick();
    tick();
    chk("to access penable", 32'(PENABLE), 32'h1);
    for (int c = 0; c < 15; c++) begin
      tick();
      chk("to wait ack", 32'(ack), 32'h0);
    end
    tick();
    chk("to ack",   32'(ack), 32'h1);
    chk("to err",   32'(rsp_err), 32'h1);
    chk("to rdata", rsp_rdata, 32'h0);
    req = 2'b00;
    tick();
    chk("to idle busy", 32'(busy), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
